i2c_target: RTL and testbench

I2C target (slave) responder for the MiniLED board's serial bus, the peer of the existing I2C controller. It answers a fixed 7-bit address, receives write bytes and presents them on a strobed byte port, and serves read bytes through a per-byte request handshake. SCL and SDA are oversampled in the `I_clk` domain. The block is the local register-interface front end for an on-board peripheral and is also the bus model used in controller testbenches.

---
 rtl/i2c_target.sv | 213 +++++++++++++++++++++
 tb/tb_i2c_target.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target.sv
// I2C target responder: answers one fixed 7-bit address, delivers write bytes on a strobed
// port and fetches read bytes through a per-byte request handshake. SCL/SDA are oversampled.
module i2c_target #(
    parameter logic [6:0] I2C_ADDR = 7'h1E
) (
    input  logic       I_clk,
    input  logic       I_rst_n,
    input  logic       I_scl,
    inout  wire        sda,
    output logic [7:0] O_rx_data,
    output logic       O_rx_valid,
    input  logic [7:0] I_tx_data,
    output logic       O_tx_req,
    output logic       O_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_ADDR_ACK,
        S_WR_BYTE,
        S_WR_ACK,
        S_RD_BYTE,
        S_RD_ACK,
        S_IGNORE
    } state_t;

    logic       scl_meta_q, scl_sync_q, scl_prev_q;
    logic       sda_meta_q, sda_sync_q, sda_prev_q;

    state_t     state_q, state_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       rw_q, rw_d;
    logic       sda_oe_q, sda_oe_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_req_q, tx_req_d;
    logic       busy_q, busy_d;

    logic       scl_rise, scl_fall, start_det, stop_det;
    logic [7:0] shift_in;

    // Synchronizers reset to the idle-bus level so leaving reset creates no phantom edges.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            scl_meta_q <= 1'b1;
            scl_sync_q <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_meta_q <= 1'b1;
            sda_sync_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_meta_q <= I_scl;
            scl_sync_q <= scl_meta_q;
            scl_prev_q <= scl_sync_q;
            sda_meta_q <= sda;
            sda_sync_q <= sda_meta_q;
            sda_prev_q <= sda_sync_q;
        end
    end

    assign scl_rise  = scl_sync_q & ~scl_prev_q;
    assign scl_fall  = ~scl_sync_q & scl_prev_q;
    assign start_det = scl_sync_q & sda_prev_q & ~sda_sync_q;
    assign stop_det  = scl_sync_q & ~sda_prev_q & sda_sync_q;
    assign shift_in  = {shift_q[6:0], sda_sync_q};

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q    <= S_IDLE;
            shift_q    <= 8'h00;
            bit_cnt_q  <= 3'd7;
            rw_q       <= 1'b0;
            sda_oe_q   <= 1'b0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            rw_q       <= rw_d;
            sda_oe_q   <= sda_oe_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            tx_req_q   <= tx_req_d;
            busy_q     <= busy_d;
        end
    end

    // In the ACK states, sda_oe_q tells the first falling edge (start driving) from the second.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        rw_d       = rw_q;
        sda_oe_d   = sda_oe_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        tx_req_d   = 1'b0;
        busy_d     = busy_q;

        if (start_det) begin
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
            bit_cnt_d = 3'd7;
            state_d   = S_ADDR;
        end else if (stop_det) begin
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
            state_d  = S_IDLE;
        end else begin
            case (state_q)
                S_ADDR: begin
                    if (scl_rise) begin
                        shift_d = shift_in;
                        if (bit_cnt_q == 3'd0) begin
                            if (shift_in[7:1] == I2C_ADDR) begin
                                rw_d    = shift_in[0];
                                state_d = S_ADDR_ACK;
                            end else begin
                                state_d = S_IGNORE;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q - 3'd1;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                            busy_d   = 1'b1;
                        end else if (rw_q) begin
                            shift_d   = I_tx_data;
                            sda_oe_d  = ~I_tx_data[7];
                            bit_cnt_d = 3'd7;
                            state_d   = S_RD_BYTE;
                        end else begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 3'd7;
                            state_d   = S_WR_BYTE;
                        end
                    end else if (scl_rise && sda_oe_q && rw_q) begin
                        tx_req_d = 1'b1;
                    end
                end
                S_WR_BYTE: begin
                    if (scl_rise) begin
                        shift_d = shift_in;
                        if (bit_cnt_q == 3'd0) begin
                            rx_data_d  = shift_in;
                            rx_valid_d = 1'b1;
                            state_d    = S_WR_ACK;
                        end else begin
                            bit_cnt_d = bit_cnt_q - 3'd1;
                        end
                    end
                end
                S_WR_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                        end else begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = 3'd7;
                            state_d   = S_WR_BYTE;
                        end
                    end
                end
                S_RD_BYTE: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 3'd0) begin
                            sda_oe_d = 1'b0;
                            state_d  = S_RD_ACK;
                        end else begin
                            bit_cnt_d = bit_cnt_q - 3'd1;
                            shift_d   = {shift_q[6:0], 1'b0};
                            sda_oe_d  = ~shift_q[6];
                        end
                    end
                end
                S_RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_sync_q) begin
                            busy_d  = 1'b0;
                            state_d = S_IGNORE;
                        end else begin
                            tx_req_d = 1'b1;
                        end
                    end else if (scl_fall) begin
                        shift_d   = I_tx_data;
                        sda_oe_d  = ~I_tx_data[7];
                        bit_cnt_d = 3'd7;
                        state_d   = S_RD_BYTE;
                    end
                end
                default: begin
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    assign sda        = sda_oe_q ? 1'b0 : 1'bz;
    assign O_rx_data  = rx_data_q;
    assign O_rx_valid = rx_valid_q;
    assign O_tx_req   = tx_req_q;
    assign O_busy     = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: a bit-banged bus master plus a transaction-level model of what the
// target should ACK, receive and send, driven by directed scenarios and random transfers.
module tb_i2c_target;

    localparam logic [6:0] TGT_ADDR = 7'h1E;
    localparam int         QTR      = 10;

    logic       I_clk        = 1'b0;
    logic       I_rst_n      = 1'b0;
    logic       I_scl        = 1'b1;
    logic       masterSdaLow = 1'b0;
    logic [7:0] I_tx_data    = 8'h00;
    logic [7:0] O_rx_data;
    logic       O_rx_valid;
    logic       O_tx_req;
    logic       O_busy;
    wire        sdaBus;

    assign sdaBus = masterSdaLow ? 1'b0 : 1'bz;
    pullup (sdaBus);

    always #5 I_clk = ~I_clk;

    i2c_target #(.I2C_ADDR(TGT_ADDR)) dut (
        .I_clk     (I_clk),
        .I_rst_n   (I_rst_n),
        .I_scl     (I_scl),
        .sda       (sdaBus),
        .O_rx_data (O_rx_data),
        .O_rx_valid(O_rx_valid),
        .I_tx_data (I_tx_data),
        .O_tx_req  (O_tx_req),
        .O_busy    (O_busy)
    );

    int         checkCount = 0;
    int         errorCount = 0;
    int         txReqCount = 0;
    int         targetDriveCount = 0;
    logic [7:0] rxSeen[$];
    logic [7:0] payload[$];

    always @(negedge I_clk) begin
        if (O_rx_valid === 1'b1) rxSeen.push_back(O_rx_data);
        if (O_tx_req === 1'b1) txReqCount++;
        if (sdaBus === 1'b0 && !masterSdaLow) targetDriveCount++;
    end

    initial begin
        #20ms;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic waitQ();
        repeat (QTR) @(posedge I_clk);
        #1;
    endtask

    task automatic sendStart();
        masterSdaLow = 1'b0;
        waitQ();
        I_scl = 1'b1;
        waitQ();
        masterSdaLow = 1'b1;
        waitQ();
        I_scl = 1'b0;
        waitQ();
    endtask

    task automatic sendStop();
        masterSdaLow = 1'b1;
        waitQ();
        I_scl = 1'b1;
        waitQ();
        masterSdaLow = 1'b0;
        waitQ();
    endtask

    task automatic clockBit(input logic b, output logic sampled);
        masterSdaLow = ~b;
        waitQ();
        I_scl = 1'b1;
        waitQ();
        sampled = sdaBus;
        waitQ();
        I_scl = 1'b0;
        waitQ();
    endtask

    task automatic writeByte(input logic [7:0] d, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clockBit(d[i], s);
        clockBit(1'b1, ack);
    endtask

    // Reference model: a matched write ACKs and delivers every byte; a matched read serves
    // payload bytes MSB first, one request per byte; anything else leaves the bus untouched.
    task automatic applyStimulus(input string name, input logic [6:0] addr, input logic rw,
                                 input bit doStop);
        bit         matched  = (addr == TGT_ADDR);
        int         n        = payload.size();
        int         rxBefore = rxSeen.size();
        int         txBefore = txReqCount;
        int         drvBefore = targetDriveCount;
        logic       ack;
        logic       s;
        logic [7:0] got;
        if (rw) I_tx_data = payload[0];
        sendStart();
        writeByte({addr, rw}, ack);
        checkOutput({name, " addr ack"}, 32'(ack), matched ? 32'd0 : 32'd1);
        checkOutput({name, " busy after addr"}, 32'(O_busy), 32'(matched));
        for (int i = 0; i < n; i++) begin
            if (!rw) begin
                writeByte(payload[i], ack);
                checkOutput({name, " data ack"}, 32'(ack), matched ? 32'd0 : 32'd1);
            end else begin
                for (int b = 7; b >= 0; b--) begin
                    clockBit(1'b1, s);
                    got[b] = s;
                end
                checkOutput({name, " read byte"}, 32'(got), matched ? 32'(payload[i]) : 32'hFF);
                if (i + 1 < n) I_tx_data = payload[i + 1];
                clockBit((i + 1 < n) ? 1'b0 : 1'b1, s);
            end
        end
        checkOutput({name, " busy at end"}, 32'(O_busy), 32'(matched && !rw));
        if (doStop) begin
            sendStop();
            checkOutput({name, " busy after stop"}, 32'(O_busy), 32'd0);
        end
        checkOutput({name, " rx count"}, 32'(rxSeen.size() - rxBefore),
                    (matched && !rw) ? 32'(n) : 32'd0);
        if (matched && !rw && rxSeen.size() - rxBefore == n) begin
            for (int i = 0; i < n; i++)
                checkOutput({name, " rx data"}, 32'(rxSeen[rxBefore + i]), 32'(payload[i]));
        end
        checkOutput({name, " tx_req count"}, 32'(txReqCount - txBefore),
                    (matched && rw) ? 32'(n) : 32'd0);
        if (!matched)
            checkOutput({name, " sda never driven"}, 32'(targetDriveCount - drvBefore), 32'd0);
    endtask

    initial begin
        logic       ack;
        logic       s;
        int         rxBefore;
        logic [6:0] addr;

        repeat (3) @(posedge I_clk);
        #1;
        checkOutput("reset rx_data", 32'(O_rx_data), 32'd0);
        checkOutput("reset rx_valid", 32'(O_rx_valid), 32'd0);
        checkOutput("reset tx_req", 32'(O_tx_req), 32'd0);
        checkOutput("reset busy", 32'(O_busy), 32'd0);
        checkOutput("reset sda", 32'(sdaBus), 32'd1);
        I_rst_n = 1'b1;
        waitQ();

        payload = '{8'hA7};
        applyStimulus("write", 7'h1E, 1'b0, 1'b1);

        payload = '{8'h55};
        applyStimulus("mismatch", 7'h1F, 1'b0, 1'b1);

        payload = '{8'hA5, 8'h3C};
        applyStimulus("read", 7'h1E, 1'b1, 1'b1);

        payload = '{8'h01};
        applyStimulus("rs write", 7'h1E, 1'b0, 1'b0);
        payload = '{8'h96};
        applyStimulus("rs read", 7'h1E, 1'b1, 1'b1);
        checkOutput("rs rx_data held", 32'(O_rx_data), 32'h01);

        rxBefore = rxSeen.size();
        sendStart();
        writeByte({TGT_ADDR, 1'b0}, ack);
        for (int i = 0; i < 4; i++) clockBit(1'b1, s);
        sendStop();
        checkOutput("abort rx count", 32'(rxSeen.size() - rxBefore), 32'd0);
        checkOutput("abort busy", 32'(O_busy), 32'd0);
        checkOutput("abort sda", 32'(sdaBus), 32'd1);
        payload = '{8'hC3, 8'h5A};
        applyStimulus("after abort", 7'h1E, 1'b0, 1'b1);

        for (int t = 0; t < 10; t++) begin
            addr = TGT_ADDR;
            if ($urandom_range(0, 3) == 0) begin
                addr = 7'($urandom);
                if (addr == TGT_ADDR) addr = addr ^ 7'h01;
            end
            payload = {};
            for (int i = 0; i < int'($urandom_range(1, 3)); i++) payload.push_back(8'($urandom));
            applyStimulus("random", addr, 1'($urandom), 1'b1);
        end

        sendStart();
        for (int i = 6; i >= 0; i--) clockBit(TGT_ADDR[i], s);
        clockBit(1'b0, s);
        masterSdaLow = 1'b0;
        waitQ();
        I_scl = 1'b1;
        waitQ();
        checkOutput("ack driven before reset", 32'(sdaBus), 32'd0);
        I_rst_n = 1'b0;
        #1;
        checkOutput("reset mid-ack sda", 32'(sdaBus), 32'd1);
        checkOutput("reset mid-ack busy", 32'(O_busy), 32'd0);
        checkOutput("reset mid-ack rx_data", 32'(O_rx_data), 32'd0);
        checkOutput("reset mid-ack rx_valid", 32'(O_rx_valid), 32'd0);
        checkOutput("reset mid-ack tx_req", 32'(O_tx_req), 32'd0);
        waitQ();
        I_rst_n = 1'b1;
        I_scl = 1'b0;
        waitQ();
        sendStop();

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
